// File: rtl/alu_decode_issue.sv
// alu_decode_issue: MIPS ALU-op decoder in front of a 2-entry issue FIFO.
// Ports: clk/rst (async active-high), in_valid/in_ready + instr, rs_val,
// rt_val upstream; flush; out_valid/out_ready + alu_control, operand_a,
// operand_b, shamt, illegal downstream (head entry).
// Optional macro ALU_DECODE_SHIFT_EN enables SLL/SRL/SRA decode.
module alu_decode_issue (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] instr,
  input  logic [31:0] rs_val,
  input  logic [31:0] rt_val,
  input  logic        flush,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [3:0]  alu_control,
  output logic [31:0] operand_a,
  output logic [31:0] operand_b,
  output logic [4:0]  shamt,
  output logic        illegal
);

  typedef struct packed {
    logic        illegal;
    logic [3:0]  alu;
    logic [31:0] a;
    logic [31:0] b;
    logic [4:0]  shamt;
  } entry_t;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_e;

  localparam logic [1:0] B_RT   = 2'd0;
  localparam logic [1:0] B_SEXT = 2'd1;
  localparam logic [1:0] B_ZEXT = 2'd2;

  logic [5:0] opcode;
  logic [5:0] funct;
  logic       ok;
  logic       is_r;
  logic       nop;
  logic [3:0] op;
  logic [1:0] bsel;
  entry_t     dec;

  assign opcode = instr[31:26];
  assign funct  = instr[5:0];

  always_comb begin
    ok   = 1'b1;
    is_r = 1'b0;
    nop  = 1'b0;
    op   = 4'b0000;
    bsel = B_RT;
    unique case (opcode)
      6'h00: begin
        is_r = 1'b1;
        unique case (funct)
          6'h20, 6'h21: op = 4'b0010;
          6'h22, 6'h23: op = 4'b0110;
          6'h24:        op = 4'b0000;
          6'h25:        op = 4'b0001;
          6'h26:        op = 4'b0011;
          6'h27:        op = 4'b1100;
          6'h2A:        op = 4'b0111;
`ifdef ALU_DECODE_SHIFT_EN
          6'h00:        op = 4'b1000;
          6'h02:        op = 4'b1001;
          6'h03:        op = 4'b1010;
`else
          // Only the all-zero NOP survives with shifts disabled.
          6'h00: begin
            if (instr == 32'h0) begin
              op  = 4'b1000;
              nop = 1'b1;
            end else begin
              ok = 1'b0;
            end
          end
`endif
          default:      ok = 1'b0;
        endcase
      end
      6'h08, 6'h09, 6'h23, 6'h2B: begin
        op   = 4'b0010;
        bsel = B_SEXT;
      end
      6'h0A: begin
        op   = 4'b0111;
        bsel = B_SEXT;
      end
      6'h04, 6'h05: op = 4'b0110;
      6'h0C: begin
        op   = 4'b0000;
        bsel = B_ZEXT;
      end
      6'h0D: begin
        op   = 4'b0001;
        bsel = B_ZEXT;
      end
      6'h0E: begin
        op   = 4'b0011;
        bsel = B_ZEXT;
      end
      6'h0F: begin
        op   = 4'b1101;
        bsel = B_ZEXT;
      end
      default: ok = 1'b0;
    endcase
  end

  always_comb begin
    dec = '0;
    if (!ok) begin
      dec.illegal = 1'b1;
    end else begin
      dec.alu = op;
      if (!nop) begin
        dec.a = rs_val;
        case (bsel)
          B_SEXT:  dec.b = {{16{instr[15]}}, instr[15:0]};
          B_ZEXT:  dec.b = {16'h0, instr[15:0]};
          default: dec.b = rt_val;
        endcase
        dec.shamt = is_r ? instr[10:6] : 5'd0;
      end
    end
  end

  state_e state_q, state_d;
  entry_t slot0_q, slot0_d;
  entry_t slot1_q, slot1_d;
  logic   push;
  logic   pop;

  assign push = in_valid && in_ready;
  assign pop  = out_valid && out_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= EMPTY;
      slot0_q <= '0;
      slot1_q <= '0;
    end else begin
      state_q <= state_d;
      slot0_q <= slot0_d;
      slot1_q <= slot1_d;
    end
  end

  // slot0 is always the head; slot1 shifts down on a pop from FULL.
  always_comb begin
    state_d = state_q;
    slot0_d = slot0_q;
    slot1_d = slot1_q;
    if (flush) begin
      state_d = EMPTY;
    end else begin
      unique case (state_q)
        EMPTY: begin
          if (push) begin
            state_d = ONE;
            slot0_d = dec;
          end
        end
        ONE: begin
          if (push && pop) begin
            slot0_d = dec;
          end else if (push) begin
            state_d = FULL;
            slot1_d = dec;
          end else if (pop) begin
            state_d = EMPTY;
          end
        end
        FULL: begin
          if (pop) begin
            slot0_d = slot1_q;
            if (push) slot1_d = dec;
            else      state_d = ONE;
          end
        end
        default: state_d = EMPTY;
      endcase
    end
  end

  always_comb begin
    out_valid   = (state_q != EMPTY);
    in_ready    = (state_q != FULL) || out_ready;
    illegal     = 1'b0;
    alu_control = 4'b0000;
    operand_a   = 32'h0;
    operand_b   = 32'h0;
    shamt       = 5'd0;
    if (out_valid) begin
      illegal     = slot0_q.illegal;
      alu_control = slot0_q.alu;
      operand_a   = slot0_q.a;
      operand_b   = slot0_q.b;
      shamt       = slot0_q.shamt;
    end
  end

endmodule

// File: tb/tb_alu_decode_issue.sv
// tb_alu_decode_issue: directed and random checks of alu_decode_issue
// against a queue-based FIFO model with a table-driven decode reference.
module tb_alu_decode_issue;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        flush = 1'b0;
  logic        out_ready = 1'b0;
  logic [31:0] instr = 32'h0;
  logic [31:0] rs_val = 32'h0;
  logic [31:0] rt_val = 32'h0;
  logic        in_ready;
  logic        out_valid;
  logic        illegal;
  logic [3:0]  alu_control;
  logic [31:0] operand_a;
  logic [31:0] operand_b;
  logic [4:0]  shamt;

  int vectors = 0;
  int miscompares = 0;
  logic [73:0] q[$];
  logic [73:0] got;

  assign got = {illegal, alu_control, operand_a, operand_b, shamt};

  always #5 clk = ~clk;

  alu_decode_issue dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .instr(instr), .rs_val(rs_val), .rt_val(rt_val),
    .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready),
    .alu_control(alu_control),
    .operand_a(operand_a), .operand_b(operand_b),
    .shamt(shamt), .illegal(illegal)
  );

  function automatic logic [73:0] ref_decode(
    input logic [31:0] i, input logic [31:0] rs, input logic [31:0] rt);
    logic [31:0] se;
    logic [31:0] ze;
    logic [73:0] bad;
    se  = {{16{i[15]}}, i[15:0]};
    ze  = {16'h0, i[15:0]};
    bad = {1'b1, 73'b0};
    if (i[31:26] == 6'h00) begin
      case (i[5:0])
        6'h20, 6'h21: return {1'b0, 4'b0010, rs, rt, i[10:6]};
        6'h22, 6'h23: return {1'b0, 4'b0110, rs, rt, i[10:6]};
        6'h24: return {1'b0, 4'b0000, rs, rt, i[10:6]};
        6'h25: return {1'b0, 4'b0001, rs, rt, i[10:6]};
        6'h26: return {1'b0, 4'b0011, rs, rt, i[10:6]};
        6'h27: return {1'b0, 4'b1100, rs, rt, i[10:6]};
        6'h2A: return {1'b0, 4'b0111, rs, rt, i[10:6]};
`ifdef ALU_DECODE_SHIFT_EN
        6'h00: return {1'b0, 4'b1000, rs, rt, i[10:6]};
        6'h02: return {1'b0, 4'b1001, rs, rt, i[10:6]};
        6'h03: return {1'b0, 4'b1010, rs, rt, i[10:6]};
`else
        6'h00: return (i == 32'h0) ? {1'b0, 4'b1000, 69'b0} : bad;
`endif
        default: return bad;
      endcase
    end
    case (i[31:26])
      6'h08, 6'h09, 6'h23, 6'h2B: return {1'b0, 4'b0010, rs, se, 5'd0};
      6'h0A: return {1'b0, 4'b0111, rs, se, 5'd0};
      6'h04, 6'h05: return {1'b0, 4'b0110, rs, rt, 5'd0};
      6'h0C: return {1'b0, 4'b0000, rs, ze, 5'd0};
      6'h0D: return {1'b0, 4'b0001, rs, ze, 5'd0};
      6'h0E: return {1'b0, 4'b0011, rs, ze, 5'd0};
      6'h0F: return {1'b0, 4'b1101, rs, ze, 5'd0};
      default: return bad;
    endcase
  endfunction

  function automatic logic [31:0] gen_instr();
    logic [5:0]  fn[14] = '{6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25,
                            6'h26, 6'h27, 6'h2A, 6'h00, 6'h02, 6'h03,
                            6'h08, 6'h3B};
    logic [5:0]  opc[14] = '{6'h08, 6'h09, 6'h23, 6'h2B, 6'h0A, 6'h04,
                             6'h05, 6'h0C, 6'h0D, 6'h0E, 6'h0F, 6'h3F,
                             6'h02, 6'h20};
    logic [31:0] r;
    int          k;
    r = $urandom();
    k = $urandom_range(0, 9);
    if (k < 5) return {6'h00, r[25:6], fn[$urandom_range(0, 13)]};
    if (k < 9) return {opc[$urandom_range(0, 13)], r[25:0]};
    if (k == 9 && r[0]) return 32'h0;
    return r;
  endfunction

  task automatic drive(input logic iv, input logic [31:0] ins,
                       input logic [31:0] a, input logic [31:0] b,
                       input logic ordy, input logic fl);
    @(negedge clk);
    in_valid  = iv;
    instr     = ins;
    rs_val    = a;
    rt_val    = b;
    out_ready = ordy;
    flush     = fl;
    #1;
  endtask

  task automatic commit();
    bit          push;
    bit          pop;
    logic [73:0] e;
    push = in_valid && (q.size() < 2 || out_ready);
    pop  = (q.size() > 0) && out_ready;
    e    = ref_decode(instr, rs_val, rt_val);
    @(posedge clk);
    if (flush) begin
      q.delete();
    end else begin
      if (pop) void'(q.pop_front());
      if (push) q.push_back(e);
    end
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    #1;
    vectors++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || got !== 74'h0) begin
      miscompares++;
      $display("FAIL reset: v=%b r=%b out=%h, want v=0 r=1 out=0",
               out_valid, in_ready, got);
    end
    rst = 1'b0;
    q.delete();
  endtask

  task automatic test_add();
    drive(1'b1, 32'h00A62020, 32'd5, 32'd7, 1'b1, 1'b0);
    vectors++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL add_pre: r=%b v=%b, want r=1 v=0", in_ready, out_valid);
    end
    commit();
    drive(1'b0, 32'h0, 32'h0, 32'h0, 1'b1, 1'b0);
    vectors++;
    if (out_valid !== 1'b1 || alu_control !== 4'b0010 ||
        operand_a !== 32'd5 || operand_b !== 32'd7 ||
        illegal !== 1'b0 || got !== q[0]) begin
      miscompares++;
      $display("FAIL add: v=%b out=%h, want v=1 out=%h",
               out_valid, got, q[0]);
    end
    commit();
  endtask

  task automatic test_imm();
    logic [31:0] ins[2] = '{32'h2022FFFF, 32'h3422FFFF};
    logic [31:0] exp_b[2] = '{32'hFFFFFFFF, 32'h0000FFFF};
    logic [3:0]  exp_c[2] = '{4'b0010, 4'b0001};
    drive(1'b1, ins[0], 32'h10, 32'h99, 1'b1, 1'b0);
    commit();
    for (int i = 0; i < 2; i++) begin
      drive(i == 0, ins[1], 32'h10, 32'h99, 1'b1, 1'b0);
      vectors++;
      if (out_valid !== 1'b1 || operand_b !== exp_b[i] ||
          alu_control !== exp_c[i] || operand_a !== 32'h10 ||
          got !== q[0]) begin
        miscompares++;
        $display("FAIL imm%0d: v=%b ctl=%b b=%h, want ctl=%b b=%h",
                 i, out_valid, alu_control, operand_b, exp_c[i], exp_b[i]);
      end
      commit();
    end
  endtask

  task automatic test_backpressure();
    logic [31:0] ins[3] = '{32'h00221822, 32'h00432024, 32'h0064282A};
    logic        iv[7]  = '{1, 1, 1, 1, 0, 0, 0};
    int          ix[7]  = '{0, 1, 2, 2, 0, 0, 0};
    logic        ordy[7] = '{0, 0, 0, 1, 1, 1, 1};
    logic        rdy[7] = '{1, 1, 0, 1, 1, 1, 1};
    int          hd[7]  = '{-1, 0, 0, 0, 1, 2, -1};
    logic [73:0] e;
    for (int s = 0; s < 7; s++) begin
      drive(iv[s], ins[ix[s]], 32'h100 + s, 32'h200 + ix[s], ordy[s], 1'b0);
      vectors++;
      e = (hd[s] >= 0) ? q[0] : 74'h0;
      if (in_ready !== rdy[s] || out_valid !== (hd[s] >= 0) ||
          q.size() !== ((hd[s] >= 0) ? q.size() : 0) ||
          (hd[s] >= 0 && got !== e)) begin
        miscompares++;
        $display("FAIL bp%0d: r=%b v=%b out=%h, want r=%b v=%0d out=%h",
                 s, in_ready, out_valid, got, rdy[s], hd[s] >= 0, e);
      end
      if (hd[s] >= 0) begin
        vectors++;
        if (operand_b !== 32'h200 + hd[s]) begin
          miscompares++;
          $display("FAIL bp_order%0d: b=%h, want %h",
                   s, operand_b, 32'h200 + hd[s]);
        end
      end
      commit();
    end
  endtask

  task automatic test_illegal();
    drive(1'b1, 32'hFC000000, 32'h55, 32'h66, 1'b1, 1'b0);
    commit();
    drive(1'b0, 32'h0, 32'h0, 32'h0, 1'b1, 1'b0);
    vectors++;
    if (out_valid !== 1'b1 || illegal !== 1'b1 || alu_control !== 4'b0 ||
        operand_a !== 32'h0 || operand_b !== 32'h0 || shamt !== 5'd0) begin
      miscompares++;
      $display("FAIL illegal: v=%b out=%h, want v=1 illegal entry",
               out_valid, got);
    end
    commit();
    drive(1'b0, 32'h0, 32'h0, 32'h0, 1'b1, 1'b0);
    vectors++;
    if (out_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL illegal_drain: v=%b, want 0", out_valid);
    end
    commit();
  endtask

  task automatic test_flush();
    drive(1'b1, 32'h00221820, 32'h1, 32'h2, 1'b0, 1'b0);
    commit();
    drive(1'b1, 32'h00221825, 32'h3, 32'h4, 1'b0, 1'b0);
    commit();
    drive(1'b1, 32'h00221826, 32'h5, 32'h6, 1'b0, 1'b1);
    vectors++;
    if (in_ready !== 1'b0 || out_valid !== 1'b1) begin
      miscompares++;
      $display("FAIL flush_full: r=%b v=%b, want r=0 v=1",
               in_ready, out_valid);
    end
    commit();
    drive(1'b0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0);
    vectors++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL flush: v=%b r=%b, want v=0 r=1", out_valid, in_ready);
    end
    commit();
  endtask

  task automatic test_shift();
    logic [73:0] exp_sra;
    logic [73:0] exp_nop;
`ifdef ALU_DECODE_SHIFT_EN
    exp_sra = {1'b0, 4'b1010, 32'hA, 32'hB, 5'd4};
    exp_nop = {1'b0, 4'b1000, 32'hA, 32'hB, 5'd0};
`else
    exp_sra = {1'b1, 73'b0};
    exp_nop = {1'b0, 4'b1000, 69'b0};
`endif
    drive(1'b1, 32'h00071903, 32'hA, 32'hB, 1'b1, 1'b0);
    commit();
    drive(1'b1, 32'h00000000, 32'hA, 32'hB, 1'b1, 1'b0);
    vectors++;
    if (out_valid !== 1'b1 || got !== exp_sra) begin
      miscompares++;
      $display("FAIL sra: v=%b out=%h, want %h", out_valid, got, exp_sra);
    end
    commit();
    drive(1'b0, 32'h0, 32'h0, 32'h0, 1'b1, 1'b0);
    vectors++;
    if (out_valid !== 1'b1 || got !== exp_nop) begin
      miscompares++;
      $display("FAIL nop: v=%b out=%h, want %h", out_valid, got, exp_nop);
    end
    commit();
  endtask

  task automatic test_reset_mid();
    drive(1'b1, 32'h00221820, 32'h1, 32'h2, 1'b0, 1'b0);
    commit();
    drive(1'b1, 32'h00221822, 32'h3, 32'h4, 1'b0, 1'b0);
    commit();
    @(negedge clk);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    rst       = 1'b1;
    #1;
    for (int c = 0; c < 3; c++) begin
      vectors++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1 || got !== 74'h0) begin
        miscompares++;
        $display("FAIL rst_mid%0d: v=%b r=%b out=%h, want v=0 r=1 out=0",
                 c, out_valid, in_ready, got);
      end
      if (c < 2) begin
        @(negedge clk);
        #1;
      end
    end
    rst = 1'b0;
    q.delete();
    drive(1'b0, 32'h0, 32'h0, 32'h0, 1'b1, 1'b0);
    vectors++;
    if (out_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL rst_mid_after: v=%b, want 0", out_valid);
    end
    commit();
  endtask

  task automatic test_random();
    logic [73:0] e;
    for (int n = 0; n < 400; n++) begin
      drive($urandom_range(0, 3) != 0, gen_instr(), $urandom(), $urandom(),
            $urandom_range(0, 2) != 0, $urandom_range(0, 19) == 0);
      vectors++;
      e = (q.size() != 0) ? q[0] : 74'h0;
      if (out_valid !== (q.size() != 0) ||
          in_ready !== (q.size() < 2 || out_ready) ||
          (q.size() != 0 && got !== e)) begin
        miscompares++;
        $display("FAIL random%0d: v=%b r=%b out=%h, want n=%0d out=%h",
                 n, out_valid, in_ready, got, q.size(), e);
      end
      commit();
    end
  endtask

  initial begin
    test_reset();
    test_add();
    test_imm();
    test_backpressure();
    test_illegal();
    test_flush();
    test_shift();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
